// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the systolic array: buffers one ROW x ROW matrix column by
// column, then streams it into the row lanes with lane i delayed by i cycles.
module systolic_skew_feeder #(
  parameter int ROW = 4,
  parameter int DW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW*DW-1:0] in_data,
  input  logic              arr_en,
  output logic [ROW*DW-1:0] out_data,
  output logic [ROW-1:0]    out_lane_vld,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(2*ROW);
  localparam int CW = $clog2(ROW);
  localparam logic [TW-1:0] T_LAST = TW'(2*ROW-2);
  localparam logic [CW-1:0] K_LAST = CW'(ROW-1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [TW-1:0]     t_q, t_d;
  logic [DW-1:0]     mat_q [ROW][ROW];
  logic [DW-1:0]     mat_d [ROW][ROW];
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ROW-1:0]    vld_q, vld_d;
  logic [ROW*DW-1:0] data_q, data_d;
  int                j;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = t_q;
    mat_d    = mat_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < ROW; i++) mat_d[i][ld_cnt_q] = in_data[i*DW +: DW];
          if (ld_cnt_q == K_LAST) begin
            ld_cnt_d = '0;
            t_d      = '0;
            state_d  = S_STREAM;
          end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
          end
        end
      end
      S_STREAM: begin
        if (arr_en) begin
          if (t_q == T_LAST) state_d = S_DONE;
          else               t_d     = t_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_LOAD;
      default: begin
        state_d  = S_LOAD;
        ld_cnt_d = '0;
        t_d      = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next-cycle state and wavefront index.
  always_comb begin
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_STREAM) || (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    vld_d      = '0;
    data_d     = '0;
    j          = 0;
    if (state_d == S_STREAM) begin
      for (int i = 0; i < ROW; i++) begin
        j = int'(t_d) - i;
        if (j >= 0 && j < ROW) begin
          vld_d[i]           = 1'b1;
          data_d[i*DW +: DW] = mat_d[i][j[CW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      ld_cnt_q   <= '0;
      t_q        <= '0;
      for (int i = 0; i < ROW; i++)
        for (int k = 0; k < ROW; k++) mat_q[i][k] <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      t_q        <= t_d;
      mat_q      <= mat_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign out_lane_vld = vld_q;
  assign out_data     = data_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed-plus-random bench for systolic_skew_feeder; expected lane values come
// from the matrix held in the bench and the skew rule lane i <- A[i][t-i].
module tb_systolic_skew_feeder;
  localparam int ROW = 4;
  localparam int DW  = 8;
  localparam int W   = ROW*DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           arr_en;
  logic [W-1:0]   out_data;
  logic [ROW-1:0] out_lane_vld;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] m [ROW][ROW];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.ROW(ROW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .arr_en       (arr_en),
    .out_data     (out_data),
    .out_lane_vld (out_lane_vld),
    .busy         (busy),
    .done         (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic rdy, input logic bsy, input logic dn);
    check({tag, "_ready"}, 64'(in_ready), 64'(rdy));
    check({tag, "_busy"},  64'(busy),     64'(bsy));
    check({tag, "_done"},  64'(done),     64'(dn));
  endtask

  // Expected lane contents at wavefront index t.
  function automatic void model(input int t, output logic [W-1:0] d, output logic [ROW-1:0] v);
    d = '0;
    v = '0;
    for (int i = 0; i < ROW; i++) begin
      if (t - i >= 0 && t - i < ROW) begin
        v[i]           = 1'b1;
        d[i*DW +: DW]  = m[i][t-i];
      end
    end
  endfunction

  task automatic fill(input bit rnd);
    for (int i = 0; i < ROW; i++)
      for (int k = 0; k < ROW; k++)
        m[i][k] = rnd ? DW'($urandom) : DW'(16*i + k);
  endtask

  function automatic logic [W-1:0] column(input int k);
    logic [W-1:0] c;
    for (int i = 0; i < ROW; i++) c[i*DW +: DW] = m[i][k];
    return c;
  endfunction

  task automatic load(input bit gaps);
    for (int k = 0; k < ROW; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        tick;
        check_ctrl("gap", 1'b1, 1'b0, 1'b0);
      end
      in_valid = 1'b1;
      in_data  = column(k);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic stream(input string tag, input int stall_at, input int stall_len,
                        input bit rnd, input bit bp, input logic [W-1:0] bp_data,
                        input int stop_at);
    int t = 0;
    int cyc = 0;
    int stalls = 0;
    logic en;
    logic [W-1:0] ed;
    logic [ROW-1:0] ev;
    while (t < 2*ROW-1 && cyc < 200) begin
      model(t, ed, ev);
      check({tag, "_data"}, 64'(out_data), 64'(ed));
      check({tag, "_vld"},  64'(out_lane_vld), 64'(ev));
      check_ctrl(tag, 1'b0, 1'b1, 1'b0);
      if (t == stop_at) return;
      en = 1'b1;
      if (rnd) en = ($urandom % 3) != 0;
      else if (t == stall_at && stalls < stall_len) en = 1'b0;
      arr_en = en;
      if (bp) begin
        in_valid = 1'b1;
        in_data  = bp_data;
      end
      tick;
      cyc++;
      if (en) t++;
      else    stalls++;
    end
    check({tag, "_fin_vld"}, 64'(out_lane_vld), 64'(0));
    check_ctrl({tag, "_fin"}, 1'b0, 1'b1, 1'b1);
    check({tag, "_latency"}, 64'(cyc), 64'(2*ROW-1+stalls));
    if (!rnd) check({tag, "_stalls"}, 64'(stalls), 64'(stall_len));
    arr_en = 1'b1;
  endtask

  task automatic after_done(input string tag);
    tick;
    check_ctrl(tag, 1'b1, 1'b0, 1'b0);
    check({tag, "_vld"}, 64'(out_lane_vld), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] saved [ROW][ROW];
    logic [W-1:0] nxt_col0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    arr_en   = 1'b0;

    // Reset then idle
    tick;
    tick;
    check("rst_vld",  64'(out_lane_vld), 64'(0));
    check("rst_data", 64'(out_data),     64'(0));
    rst = 1'b1;
    tick;
    check_ctrl("idle", 1'b1, 1'b0, 1'b0);
    check("idle_vld", 64'(out_lane_vld), 64'(0));

    // Back-to-back load, A[i][k] = 16*i+k
    arr_en = 1'b1;
    fill(1'b0);
    load(1'b0);
    stream("b2b", -1, 0, 1'b0, 1'b0, '0, -1);
    after_done("b2b_post");

    // Load with gaps, same matrix
    load(1'b1);
    stream("gaps", -1, 0, 1'b0, 1'b0, '0, -1);
    after_done("gaps_post");

    // Stall three cycles at t=2
    load(1'b0);
    stream("stall", 2, 3, 1'b0, 1'b0, '0, -1);
    after_done("stall_post");

    // Backpressure: next matrix's first column held during the stream
    saved = m;
    fill(1'b1);
    nxt_col0 = column(0);
    m = saved;
    load(1'b0);
    stream("bp", -1, 0, 1'b0, 1'b1, nxt_col0, -1);
    tick;
    check_ctrl("bp_post", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ROW; i++) m[i][0] = nxt_col0[i*DW +: DW];
    for (int i = 0; i < ROW; i++)
      for (int k = 1; k < ROW; k++) m[i][k] = DW'($urandom);
    load(1'b0);
    stream("bp_next", -1, 0, 1'b0, 1'b0, '0, -1);
    after_done("bp_next_post");

    // Reset mid-stream at t=4
    fill(1'b1);
    load(1'b0);
    stream("mid", -1, 0, 1'b0, 1'b0, '0, 4);
    rst = 1'b0;
    #1;
    check("mid_rst_vld",  64'(out_lane_vld), 64'(0));
    check("mid_rst_data", 64'(out_data),     64'(0));
    check("mid_rst_busy", 64'(busy),         64'(0));
    check("mid_rst_done", 64'(done),         64'(0));
    tick;
    check("mid_rst_done2", 64'(done), 64'(0));
    rst = 1'b1;
    tick;
    check_ctrl("mid_idle", 1'b1, 1'b0, 1'b0);
    fill(1'b1);
    load(1'b1);
    stream("mid_next", -1, 0, 1'b0, 1'b0, '0, -1);
    after_done("mid_next_post");

    // Random matrices with random array enables
    for (int r = 0; r < 4; r++) begin
      fill(1'b1);
      load(r[0]);
      stream("rnd", -1, 0, 1'b1, 1'b0, '0, -1);
      after_done("rnd_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
